// File: rtl/video_hv_timing_counter.sv
// video_hv_timing_counter
//   Free-running H/V raster counter for the 1024x768 display pipe. Produces
//   registered H/V counts, line/frame start strobes, a completed-frame counter
//   and an odd/even frame flag for the blank/sync comparator stage.
//   Build option HV_GENLOCK_EN adds an external active-low vsync input that is
//   synchronized and used to snap the raster back to the frame origin.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | counters parked at 0, waiting for run
//   RUN   | raster counting on ce; genlock edges act here only
module video_hv_timing_counter #(
    parameter int H_TOTAL  = 1344,
    parameter int V_TOTAL  = 806,
    parameter int CW       = 12,
    parameter int FC_W     = 8
`ifdef HV_GENLOCK_EN
    ,
    parameter int LOCK_WIN = 4
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic            run,
    output logic [CW-1:0]   H,
    output logic [CW-1:0]   V,
    output logic            line_start,
    output logic            frame_start,
    output logic [FC_W-1:0] frame_cnt,
    output logic            odd_frame,
    output logic            running
`ifdef HV_GENLOCK_EN
    ,
    input  logic            ext_vsync_n,
    output logic            locked
`endif
);

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   h_nxt;
    logic [CW-1:0]   v_nxt;
    logic            line_start_nxt;
    logic            frame_start_nxt;
    logic [FC_W-1:0] frame_cnt_nxt;
    logic            odd_frame_nxt;
    logic            running_nxt;

`ifdef HV_GENLOCK_EN
    localparam logic [CW-1:0] LOCK_LIM = CW'(LOCK_WIN);

    logic vsync_s1;
    logic vsync_s2;
    logic vsync_prev;
    logic vsync_fall;
    logic locked_nxt;

    // Two-stage synchronizer plus one delay flop for falling-edge detection;
    // flops idle high so a low ext_vsync_n out of reset looks like one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsync_s1   <= 1'b1;
            vsync_s2   <= 1'b1;
            vsync_prev <= 1'b1;
        end else begin
            vsync_s1   <= ext_vsync_n;
            vsync_s2   <= vsync_s1;
            vsync_prev <= vsync_s2;
        end
    end

    assign vsync_fall = vsync_prev & ~vsync_s2;
`endif

    // Next-state and next-output computation for the raster FSM.
    always_comb begin
        state_nxt       = state;
        h_nxt           = H;
        v_nxt           = V;
        line_start_nxt  = 1'b0;
        frame_start_nxt = 1'b0;
        frame_cnt_nxt   = frame_cnt;
        odd_frame_nxt   = odd_frame;
`ifdef HV_GENLOCK_EN
        locked_nxt      = locked;
`endif
        case (state)
            IDLE: begin
                h_nxt = '0;
                v_nxt = '0;
`ifdef HV_GENLOCK_EN
                locked_nxt = 1'b0;
`endif
                // Entry pulses mark the origin but are not a completed frame.
                if (run) begin
                    state_nxt       = RUN;
                    line_start_nxt  = 1'b1;
                    frame_start_nxt = 1'b1;
                end
            end
            RUN: begin
                if (!run) begin
                    state_nxt = IDLE;
                    h_nxt     = '0;
                    v_nxt     = '0;
`ifdef HV_GENLOCK_EN
                    locked_nxt = 1'b0;
`endif
                end else begin
                    if (ce) begin
                        if (H < H_LAST) begin
                            h_nxt = H + 1'b1;
                        end else begin
                            h_nxt          = '0;
                            line_start_nxt = 1'b1;
                            if (V < V_LAST) begin
                                v_nxt = V + 1'b1;
                            end else begin
                                v_nxt           = '0;
                                frame_start_nxt = 1'b1;
                                frame_cnt_nxt   = frame_cnt + 1'b1;
                                odd_frame_nxt   = ~odd_frame;
                            end
                        end
                    end
`ifdef HV_GENLOCK_EN
                    // A correction replaces whatever the ce step computed, and
                    // counts as exactly one frame even if it lands on a wrap.
                    if (vsync_fall) begin
                        if ((V == '0) && (H <= LOCK_LIM)) begin
                            locked_nxt = 1'b1;
                        end else begin
                            h_nxt           = '0;
                            v_nxt           = '0;
                            line_start_nxt  = 1'b1;
                            frame_start_nxt = 1'b1;
                            frame_cnt_nxt   = frame_cnt + 1'b1;
                            odd_frame_nxt   = ~odd_frame;
                            locked_nxt      = 1'b0;
                        end
                    end
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
                h_nxt     = '0;
                v_nxt     = '0;
            end
        endcase
        running_nxt = (state_nxt == RUN);
    end

    // Register state and every output so nothing reaches a port combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            H           <= '0;
            V           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            odd_frame   <= 1'b0;
            running     <= 1'b0;
`ifdef HV_GENLOCK_EN
            locked      <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            H           <= h_nxt;
            V           <= v_nxt;
            line_start  <= line_start_nxt;
            frame_start <= frame_start_nxt;
            frame_cnt   <= frame_cnt_nxt;
            odd_frame   <= odd_frame_nxt;
            running     <= running_nxt;
`ifdef HV_GENLOCK_EN
            locked      <= locked_nxt;
`endif
        end
    end

endmodule
